// File: rtl/lcd_timing.sv
// lcd_timing: LCD panel timing generator (HSYNC/VSYNC/DEN plus active X/Y and frame-start pulse)
// Ports:
//   i_clk          pixel clock, all logic on rising edge
//   i_rst_n        asynchronous active-low reset
//   o_hsync        line sync, active low
//   o_vsync        frame sync, active low
//   o_den          data enable, high during active pixels
//   o_x, o_y       active column/row index, 0 outside the active area
//   o_frame_start  one-cycle pulse on the first active pixel of each frame
//   o_frame        free-running 16-bit frame count (only with LCD_TIMING_FRAME_CNT_EN defined)
// Optional feature macro: LCD_TIMING_FRAME_CNT_EN
module lcd_timing #(
    parameter int LCD_WIDTH  = 480,
    parameter int LCD_HEIGHT = 272,
    parameter int H_SYNC     = 41,
    parameter int H_BACK     = 2,
    parameter int H_FRONT    = 2,
    parameter int V_SYNC     = 10,
    parameter int V_BACK     = 2,
    parameter int V_FRONT    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_den,
    output logic [10:0] o_x,
    output logic [10:0] o_y,
`ifdef LCD_TIMING_FRAME_CNT_EN
    output logic [15:0] o_frame,
`endif
    output logic        o_frame_start
);

    localparam logic [10:0] H_BEG = 11'(H_SYNC);
    localparam logic [10:0] H_ACT = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_FRT = 11'(H_SYNC + H_BACK + LCD_WIDTH);
    localparam logic [10:0] H_TOT = 11'(H_SYNC + H_BACK + LCD_WIDTH + H_FRONT);
    localparam logic [10:0] V_BEG = 11'(V_SYNC);
    localparam logic [10:0] V_ACT = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_FRT = 11'(V_SYNC + V_BACK + LCD_HEIGHT);
    localparam logic [10:0] V_TOT = 11'(V_SYNC + V_BACK + LCD_HEIGHT + V_FRONT);

    typedef enum logic [1:0] {SYNC, BACK, ACTIVE, FRONT} phase_t;

    phase_t      r_hph, r_vph, w_hph_nxt, w_vph_nxt;
    logic [10:0] r_hcnt, r_vcnt;
    logic        w_hwrap, w_vwrap, w_den, w_fs;

    assign w_hwrap = r_hcnt == H_TOT - 11'd1;
    assign w_vwrap = r_vcnt == V_TOT - 11'd1;
    assign w_den   = r_hph == ACTIVE && r_vph == ACTIVE;
    assign w_fs    = w_den && r_hcnt == H_ACT && r_vcnt == V_ACT;

    // Phase registers track the phase of the current count, so they step on
    // the last count of each phase.
    always_comb begin
        w_hph_nxt = r_hph;
        case (r_hph)
            SYNC:   if (r_hcnt == H_BEG - 11'd1) w_hph_nxt = BACK;
            BACK:   if (r_hcnt == H_ACT - 11'd1) w_hph_nxt = ACTIVE;
            ACTIVE: if (r_hcnt == H_FRT - 11'd1) w_hph_nxt = FRONT;
            FRONT:  if (w_hwrap)                 w_hph_nxt = SYNC;
        endcase
    end

    always_comb begin
        w_vph_nxt = r_vph;
        if (w_hwrap) begin
            case (r_vph)
                SYNC:   if (r_vcnt == V_BEG - 11'd1) w_vph_nxt = BACK;
                BACK:   if (r_vcnt == V_ACT - 11'd1) w_vph_nxt = ACTIVE;
                ACTIVE: if (r_vcnt == V_FRT - 11'd1) w_vph_nxt = FRONT;
                FRONT:  if (w_vwrap)                 w_vph_nxt = SYNC;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_hph  <= SYNC;
            r_vph  <= SYNC;
        end else begin
            r_hcnt <= w_hwrap ? '0 : r_hcnt + 11'd1;
            r_vcnt <= !w_hwrap ? r_vcnt : w_vwrap ? '0 : r_vcnt + 11'd1;
            r_hph  <= w_hph_nxt;
            r_vph  <= w_vph_nxt;
        end
    end

    // Outputs decode the current count, giving one cycle of latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_den         <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_hsync       <= r_hph != SYNC;
            o_vsync       <= r_vph != SYNC;
            o_den         <= w_den;
            o_x           <= w_den ? r_hcnt - H_ACT : '0;
            o_y           <= w_den ? r_vcnt - V_ACT : '0;
            o_frame_start <= w_fs;
        end
    end

`ifdef LCD_TIMING_FRAME_CNT_EN
    // Updates on the same edge as o_frame_start, so the first frame reads 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_frame <= '0;
        else          o_frame <= o_frame + 16'(w_fs);
    end
`endif

endmodule
